// File: rtl/vfd_ctrl_pkg.sv
// Shared state encoding and configuration reset defaults for the VFD frequency ramp controller.
package vfd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RAMP  = 2'd1,
        HOLD  = 2'd2,
        DECEL = 2'd3
    } state_e;

    localparam int unsigned RST_STEP   = 1;
    localparam int unsigned RST_PERIOD = 0;

endpackage

// File: rtl/vfd_tick_gen.sv
// Programmable divider: one-cycle tick every cur_div cycles and a toggling clock that parks low.
module vfd_tick_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             run,
    input  logic [DIV_W-1:0] cur_div,
    output logic             tick_out,
    output logic             clk_out,
    output logic             last_tick_high
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             tick_q, tick_d;
    logic             clk_q, clk_d;
    logic             wrap;

    // >= rather than == so a ratio that shrinks below the running count wraps at once
    assign wrap           = (div_cnt_q >= (cur_div - DIV_W'(1)));
    assign last_tick_high = run && wrap && clk_q;

    always_comb begin
        div_cnt_d = div_cnt_q;
        tick_d    = 1'b0;
        clk_d     = clk_q;
        if (!run) begin
            div_cnt_d = '0;
            clk_d     = 1'b0;
        end else if (wrap) begin
            div_cnt_d = '0;
            tick_d    = 1'b1;
            clk_d     = ~clk_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            tick_q    <= 1'b0;
            clk_q     <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            tick_q    <= tick_d;
            clk_q     <= clk_d;
        end
    end

    assign tick_out = tick_q;
    assign clk_out  = clk_q;

endmodule

// File: rtl/vfd_freq_ramp_ctrl.sv
// Soft-start/soft-stop controller: ramps the divide ratio toward a configured target and drives the tick generator.
module vfd_freq_ramp_ctrl
    import vfd_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W     = 16,
    parameter int unsigned RAMP_W    = 16,
    parameter int unsigned START_DIV = 1000,
    parameter int unsigned MIN_DIV   = 2
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_target_div,
    input  logic [DIV_W-1:0]  cfg_step,
    input  logic [RAMP_W-1:0] cfg_ramp_period,
    output logic              tick_out,
    output logic              clk_out,
    output logic [DIV_W-1:0]  cur_div,
    output logic              at_target,
    output logic              busy
);

    localparam logic [DIV_W-1:0] START_V = DIV_W'(START_DIV);
    localparam logic [DIV_W-1:0] MIN_V   = DIV_W'(MIN_DIV);

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   cur_div_q, cur_div_d;
    logic [DIV_W-1:0]   target_q, target_d;
    logic [DIV_W-1:0]   step_q, step_d;
    logic [RAMP_W-1:0]  period_q, period_d;
    logic [RAMP_W-1:0]  ramp_cnt_q, ramp_cnt_d;
    logic [DIV_W-1:0]   cfg_tgt, goal, stepped;
    logic               cfg_fire, last_tick_high;

    assign cfg_ready = (state_q == IDLE) || (state_q == HOLD);
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign busy      = (state_q != IDLE);
    assign at_target = (state_q == HOLD);
    assign cur_div   = cur_div_q;

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        target_d   = target_q;
        step_d     = step_q;
        period_d   = period_q;
        ramp_cnt_d = ramp_cnt_q;
        cfg_tgt    = (cfg_target_div < MIN_V) ? MIN_V : cfg_target_div;
        goal       = enable ? target_q : START_V;

        // Saturating move toward goal; difference tested first so neither direction wraps
        if (cur_div_q > goal) begin
            stepped = ((cur_div_q - goal) < step_q) ? goal : cur_div_q - step_q;
        end else if (cur_div_q < goal) begin
            stepped = ((goal - cur_div_q) < step_q) ? goal : cur_div_q + step_q;
        end else begin
            stepped = cur_div_q;
        end

        if (cfg_fire) begin
            target_d = cfg_tgt;
            step_d   = (cfg_step == '0) ? DIV_W'(1) : cfg_step;
            period_d = cfg_ramp_period;
        end

        case (state_q)
            IDLE: begin
                cur_div_d  = START_V;
                ramp_cnt_d = '0;
                if (enable) begin
                    state_d = (target_q != START_V) ? RAMP : HOLD;
                end
            end
            RAMP, DECEL: begin
                if (ramp_cnt_q == period_q) begin
                    ramp_cnt_d = '0;
                    cur_div_d  = stepped;
                end else begin
                    ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
                end
                if (enable) begin
                    state_d = (cur_div_d == target_q) ? HOLD : RAMP;
                end else if ((state_q == DECEL) && (cur_div_q == START_V) && last_tick_high) begin
                    state_d    = IDLE;
                    cur_div_d  = START_V;
                    ramp_cnt_d = '0;
                end else begin
                    state_d = DECEL;
                end
            end
            HOLD: begin
                ramp_cnt_d = '0;
                if (!enable) begin
                    state_d = DECEL;
                end else if (cfg_fire && (cfg_tgt != cur_div_q)) begin
                    state_d = RAMP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_div_q  <= START_V;
            target_q   <= START_V;
            step_q     <= DIV_W'(RST_STEP);
            period_q   <= RAMP_W'(RST_PERIOD);
            ramp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            target_q   <= target_d;
            step_q     <= step_d;
            period_q   <= period_d;
            ramp_cnt_q <= ramp_cnt_d;
        end
    end

    vfd_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk_in         (clk_in),
        .reset_n        (reset_n),
        .run            (busy),
        .cur_div        (cur_div_q),
        .tick_out       (tick_out),
        .clk_out        (clk_out),
        .last_tick_high (last_tick_high)
    );

endmodule

// File: tb/tb_vfd_freq_ramp_ctrl.sv
// Directed bench for vfd_freq_ramp_ctrl with a cur_div change scoreboard (value and cycle of each step).
module tb_vfd_freq_ramp_ctrl;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned RAMP_W = 16;
    localparam int          START  = 10;
    localparam int          MIN    = 2;

    logic              clk_in = 1'b0;
    logic              reset_n = 1'b0;
    logic              enable = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_target_div = '0;
    logic [DIV_W-1:0]  cfg_step = '0;
    logic [RAMP_W-1:0] cfg_ramp_period = '0;
    logic              tick_out, clk_out, at_target, busy;
    logic [DIV_W-1:0]  cur_div;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int val;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    vfd_freq_ramp_ctrl #(
        .DIV_W     (DIV_W),
        .RAMP_W    (RAMP_W),
        .START_DIV (START),
        .MIN_DIV   (MIN)
    ) dut (
        .clk_in          (clk_in),
        .reset_n         (reset_n),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_target_div  (cfg_target_div),
        .cfg_step        (cfg_step),
        .cfg_ramp_period (cfg_ramp_period),
        .tick_out        (tick_out),
        .clk_out         (clk_out),
        .cur_div         (cur_div),
        .at_target       (at_target),
        .busy            (busy)
    );

    always #5 clk_in = ~clk_in;

    initial forever begin
        @(posedge clk_in);
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every cur_div change must match the next queued value at its queued cycle
    initial begin
        int   prev;
        exp_t e;
        prev = START;
        forever begin
            @(negedge clk_in);
            if (mon_en && (int'(cur_div) != prev)) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_change", cur_div, prev);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_div", cur_div, e.val);
                    check("sb_cycle", cyc, e.cyc);
                end
            end
            prev = int'(cur_div);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic to_cyc(input int c);
        if (c > cyc) step(c - cyc);
    endtask

    task automatic push(input int v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic send_cfg(input int t, input int s, input int p);
        cfg_target_div  = DIV_W'(t);
        cfg_step        = DIV_W'(s);
        cfg_ramp_period = RAMP_W'(p);
        cfg_valid       = 1'b1;
        check("cfg_ready_offer", cfg_ready, 1);
        step(1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_tick(output int c);
        int n = 0;
        do begin
            step(1);
            n++;
        end while (tick_out !== 1'b1 && n < 50);
        if (tick_out !== 1'b1) check("wait_tick_timeout", tick_out, 1);
        c = cyc;
    endtask

    task automatic wait_rise(output int c);
        int   n = 0;
        logic p;
        logic ok = 1'b0;
        do begin
            p = clk_out;
            step(1);
            n++;
            ok = (p === 1'b0) && (clk_out === 1'b1);
        end while (!ok && n < 50);
        if (!ok) check("wait_rise_timeout", ok, 1);
        c = cyc;
    endtask

    task automatic wait_idle(output int c);
        int n = 0;
        while (busy !== 1'b0 && n < 100) begin
            step(1);
            n++;
        end
        if (busy !== 1'b0) check("wait_idle_timeout", busy, 0);
        c = cyc;
    endtask

    task automatic do_reset();
        mon_en    = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        reset_n   = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        mon_en = 1'b1;
    endtask

    initial begin
        int e0, d0, f0, c, c1, c2, c3, r1, r2;
        int run_len, max_run, nbusy, nt, nc;
        logic last;

        step(3);
        reset_n = 1'b1;
        step(1);
        check("rst_cur_div", cur_div, START);
        check("rst_tick", tick_out, 0);
        check("rst_clk", clk_out, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_at_target", at_target, 0);
        check("rst_busy", busy, 0);
        mon_en = 1'b1;

        // Clamp (target 1 -> 2), zero step treated as 1, offer during RAMP ignored
        send_cfg(1, 0, 3);
        enable = 1'b1;
        e0 = cyc + 1;
        for (int k = 1; k <= 8; k++) push(START - k, e0 + 4 * k);
        to_cyc(e0 + 10);
        cfg_target_div  = 16'd9;
        cfg_step        = 16'd5;
        cfg_ramp_period = 16'd0;
        cfg_valid       = 1'b1;
        check("cfg_ready_ramp", cfg_ready, 0);
        check("busy_ramp", busy, 1);
        step(1);
        cfg_valid = 1'b0;
        to_cyc(e0 + 31);
        check("clamp_at_target_early", at_target, 0);
        step(1);
        check("clamp_at_target", at_target, 1);
        check("clamp_div", cur_div, MIN);
        to_cyc(e0 + 40);
        wait_tick(c1);
        wait_tick(c2);
        check("clamp_tick_period", c2 - c1, 2);
        check("clamp_sb_drain", exp_q.size(), 0);
        do_reset();

        // Accelerate 10 -> 8 -> 6 -> 4, every 8 cycles
        send_cfg(4, 2, 7);
        enable = 1'b1;
        e0 = cyc + 1;
        push(8, e0 + 8);
        push(6, e0 + 16);
        push(4, e0 + 24);
        to_cyc(e0 + 23);
        check("accel_at_target_early", at_target, 0);
        step(1);
        check("accel_at_target", at_target, 1);
        to_cyc(e0 + 30);
        wait_tick(c1);
        wait_tick(c2);
        wait_tick(c3);
        check("hold_tick_period_a", c2 - c1, 4);
        check("hold_tick_period_b", c3 - c2, 4);
        wait_rise(r1);
        wait_rise(r2);
        check("hold_clk_period", r2 - r1, 8);

        // Decelerate, re-enable at cur_div 8, ramp back to 4 without idling
        enable = 1'b0;
        d0 = cyc + 1;
        push(6, d0 + 8);
        push(8, d0 + 16);
        to_cyc(d0 + 18);
        check("decel_busy", busy, 1);
        check("decel_cfg_ready", cfg_ready, 0);
        check("decel_div", cur_div, 8);
        enable = 1'b1;
        push(6, d0 + 24);
        push(4, d0 + 32);
        last = clk_out;
        run_len = 1;
        max_run = 1;
        nbusy = 0;
        while (cyc < d0 + 33) begin
            step(1);
            if (clk_out === last) run_len++;
            else begin
                run_len = 1;
                last = clk_out;
            end
            if (run_len > max_run) max_run = run_len;
            if (busy !== 1'b1) nbusy++;
        end
        check("reenable_clk_no_gap", max_run <= 8, 1);
        check("reenable_never_idle", nbusy, 0);
        check("reenable_at_target", at_target, 1);

        // Full soft stop 4 -> 10, then idle on the falling tick
        enable = 1'b0;
        f0 = cyc + 1;
        push(6, f0 + 8);
        push(8, f0 + 16);
        push(10, f0 + 24);
        wait_idle(c);
        check("stop_after_start_div", c >= f0 + 25, 1);
        check("stop_clk_low", clk_out, 0);
        check("stop_tick_on_fall", tick_out, 1);
        check("stop_div", cur_div, START);
        nt = 0;
        nc = 0;
        repeat (30) begin
            step(1);
            if (tick_out !== 1'b0) nt++;
            if (clk_out !== 1'b0) nc++;
        end
        check("stop_tick_silent", nt, 0);
        check("stop_clk_silent", nc, 0);
        check("stop_sb_drain", exp_q.size(), 0);

        // Target equal to START_DIV goes straight to HOLD; first tick latency; clean stop
        send_cfg(START, 1, 0);
        enable = 1'b1;
        e0 = cyc + 1;
        step(1);
        check("direct_hold", at_target, 1);
        wait_tick(c);
        check("first_tick_latency", c, e0 + 10);
        check("first_tick_clk_high", clk_out, 1);
        enable = 1'b0;
        wait_idle(c);
        check("direct_stop_cycle", c, e0 + 20);
        check("direct_stop_clk", clk_out, 0);
        check("direct_stop_tick", tick_out, 1);

        // Saturation: step 4 from 10 lands on 4, never 2
        send_cfg(4, 4, 7);
        enable = 1'b1;
        e0 = cyc + 1;
        push(6, e0 + 8);
        push(4, e0 + 16);
        to_cyc(e0 + 16);
        check("sat_at_target", at_target, 1);
        to_cyc(e0 + 40);
        check("sat_div", cur_div, 4);
        check("sat_sb_drain", exp_q.size(), 0);
        do_reset();

        // Asynchronous reset mid-RAMP at cur_div 7
        send_cfg(4, 1, 1);
        enable = 1'b1;
        e0 = cyc + 1;
        push(9, e0 + 2);
        push(8, e0 + 4);
        push(7, e0 + 6);
        to_cyc(e0 + 7);
        check("pre_reset_div", cur_div, 7);
        check("pre_reset_busy", busy, 1);
        mon_en = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("async_rst_div", cur_div, START);
        check("async_rst_clk", clk_out, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_cfg_ready", cfg_ready, 1);
        check("async_rst_at_target", at_target, 0);
        check("async_rst_tick", tick_out, 0);
        enable = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
        check("final_sb_drain", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vfd_freq_ramp_ctrl.md
Name: vfd_freq_ramp_ctrl

Overview:
- Programmable soft-start/soft-stop frequency controller for the VFD switching clock.
- Owns a programmable divider whose divide ratio (cur_div) ramps toward a configured target by a fixed step at a fixed update interval.
- Emits a one-cycle tick strobe and a divided clock (clk_out) consumed by the PWM/modulation stage.
- Larger cur_div means lower output frequency.

Parameters:
- DIV_W, 16: width of divide ratio, step and target.
- RAMP_W, 16: width of ramp-interval counter.
- START_DIV, 1000: divide ratio at start and stop; the lowest operating frequency.
- MIN_DIV, 2: smallest legal divide ratio; targets below it are clamped.

Ports:
- clk_in, input, 1: system clock; all logic on rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: run request. Level-sensitive: 1 = run/accelerate, 0 = decelerate and stop.
- cfg_valid, input, 1: configuration offer.
- cfg_ready, output, 1: configuration acceptance.
- cfg_target_div, input, DIV_W: requested divide ratio.
- cfg_step, input, DIV_W: ratio change per ramp update.
- cfg_ramp_period, input, RAMP_W: ramp update every cfg_ramp_period+1 cycles.
- tick_out, output, 1: one-cycle pulse every cur_div cycles.
- clk_out, output, 1: toggles on each tick; period is 2*cur_div cycles.
- cur_div, output, DIV_W: current divide ratio.
- at_target, output, 1: high when state is HOLD.
- busy, output, 1: high when state is not IDLE.

Behaviour:
- Reset values:
  - state IDLE; cur_div = START_DIV; tick_out = 0; clk_out = 0; cfg_ready = 1; at_target = 0; busy = 0.
  - Internal registers: target = START_DIV, step = 1, period = 0, div_cnt = 0, ramp_cnt = 0.
- Reset mid-operation aborts immediately to these values with no completion of the ramp.
- Config handshake:
  - Transfer when cfg_valid && cfg_ready.
  - cfg_ready = 1 in IDLE and HOLD, 0 in RAMP and DECEL.
  - On transfer, registers are set as follows: target = max(cfg_target_div, MIN_DIV); step = (cfg_step == 0) ? 1 : cfg_step; period = cfg_ramp_period.
  - Transfer in HOLD with a new target ≠ cur_div moves to RAMP the next cycle.
- States:
  - IDLE:
    - Divider stopped; div_cnt = 0; clk_out = 0; cur_div = START_DIV.
    - enable = 1 → RAMP if target ≠ START_DIV, else HOLD.
  - RAMP:
    - ramp_cnt counts 0..period.
    - At ramp_cnt == period, cur_div moves one step toward target, saturating exactly at target with no overshoot. ramp_cnt then restarts at 0.
    - cur_div == target → HOLD.
    - enable = 0 → DECEL.
  - HOLD:
    - cur_div constant; ramp_cnt held at 0.
    - enable = 0 → DECEL.
  - DECEL:
    - Same ramp rule with effective target START_DIV.
    - enable = 1 → RAMP (toward registered target), or HOLD if already equal.
    - When cur_div == START_DIV, go to IDLE only on a tick where clk_out is 1, so clk_out falls on that tick. clk_out therefore always stops low and has no runt pulse.
- Divider (active in RAMP, HOLD, DECEL):
  - div_cnt increments each cycle.
  - When div_cnt >= cur_div-1: tick_out = 1 the next cycle (registered), clk_out toggles, div_cnt = 0.
  - The >= comparison handles cur_div shrinking below div_cnt (no wrap-through to 2^DIV_W).
- Latency:
  - IDLE → active on the first edge with enable = 1.
  - First tick_out cycle is cur_div cycles later.
- Arithmetic:
  - Unsigned DIV_W.
  - Decrement uses (cur_div - target < step) ? target : cur_div - step; increment is symmetric. There is no underflow or overflow.
- Simultaneous events:
  - The ramp update and a tick in the same cycle both take effect; the tick compares against the pre-update cur_div.
  - enable falling in the same cycle as a HOLD config transfer: the config is accepted and the state goes to DECEL.

Decomposition:
- Package vfd_ctrl_pkg: state encoding (IDLE, RAMP, HOLD, DECEL as 2-bit constants) and reset defaults for step and period.
- Sub-module vfd_tick_gen:
  - Inputs: clk_in, reset_n, run, cur_div.
  - Outputs: tick_out, clk_out.
  - Contains div_cnt and the toggle logic, including the stop-on-low handshake output last_tick_high.
- The top level holds the FSM, config registers and ramp counter.

Test Plan:
- Reset: assert reset_n = 0 mid-RAMP with cur_div = 7 → the same cycle shows cur_div = 1000, clk_out = 0, busy = 0, cfg_ready = 1.
- Accelerate with START_DIV = 10, target = 4, step = 2, period = 7, then enable = 1 → cur_div 10→8→6→4 at 8-cycle intervals. at_target rises 24 cycles after enable. tick_out then pulses every 4 cycles and clk_out period is 8.
- Saturation: step = 4 with the same setup → 10→6→4, never 2.
- Clamp and handshake:
  - cfg_target_div = 1 in IDLE → target = 2.
  - cfg_valid during RAMP → cfg_ready = 0, no change.
  - cfg_step = 0 behaves as 1.
- Soft stop: enable = 0 in HOLD at cur_div = 4 → DECEL ramps 4→10, then IDLE on the tick where clk_out falls. clk_out stays 0 and tick_out stays silent thereafter.
- Re-enable during DECEL at cur_div = 8 → RAMP back to 4 without passing through IDLE; clk_out continues toggling with no gap.
